// File: rtl/me_pkg.sv
// Shared types, width helpers and constants for the block-matching motion search engine.
package me_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } me_state_t;

  // Wide enough for any SAD width; users slice the low bits they need.
  localparam logic [63:0] ME_SAD_INIT = '1;

  function automatic int sad_w(input int pix_w, input int blk_n);
    return pix_w + 2 * $clog2(blk_n);
  endfunction

  function automatic int mv_w(input int srch_p);
    return $clog2(srch_p) + 1;
  endfunction

endpackage

// File: rtl/me_sad_pe.sv
// Absolute-difference accumulator for one candidate; clear has priority and the sum saturates.
module me_sad_pe #(
  parameter int PIX_W = 8,
  parameter int ACC_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [PIX_W-1:0] i_a,
  input  logic [PIX_W-1:0] i_b,
  output logic [ACC_W-1:0] o_acc
);

  logic [PIX_W:0]   w_diff;
  logic [PIX_W-1:0] w_abs;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] r_acc;

  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_abs  = w_diff[PIX_W] ? PIX_W'(-w_diff) : w_diff[PIX_W-1:0];
  assign w_sum  = {1'b0, r_acc} + (ACC_W + 1)'(w_abs);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/motion_search_engine.sv
// Full-search block-matching motion estimator: streams the reference block and search window
// from clocked ROMs, one pixel pair per cycle, and keeps the minimum-SAD candidate.
module motion_search_engine
  import me_pkg::*;
#(
  parameter int BLOCK_N  = 16,
  parameter int SEARCH_P = 8,
  parameter int PIX_W    = 8,
  parameter bit ET_EN    = 1'b1
) (
  input  logic                                                          clock,
  input  logic                                                          reset_n,
  input  logic                                                          start,
  output logic [$clog2(BLOCK_N*BLOCK_N)-1:0]                            AddressR,
  input  logic [PIX_W-1:0]                                              R,
  output logic [$clog2((BLOCK_N+2*SEARCH_P-1)*(BLOCK_N+2*SEARCH_P-1))-1:0] AddressS,
  input  logic [PIX_W-1:0]                                              S,
  output logic [sad_w(PIX_W, BLOCK_N)-1:0]                              BestDist,
  output logic signed [mv_w(SEARCH_P)-1:0]                              motionX,
  output logic signed [mv_w(SEARCH_P)-1:0]                              motionY,
  output logic                                                          busy,
  output logic                                                          completed
);

  // state    | meaning
  // ST_IDLE  | waiting for start after reset
  // ST_RUN   | issuing one ref/window address pair per cycle for the current candidate
  // ST_DRAIN | two cycles letting the last ROM read land in the accumulator
  // ST_DONE  | result held until the next accepted start

  localparam int LN   = $clog2(BLOCK_N);
  localparam int WIN  = BLOCK_N + 2 * SEARCH_P - 1;
  localparam int AW_S = $clog2(WIN * WIN);
  localparam int SADW = sad_w(PIX_W, BLOCK_N);
  localparam int MVW  = mv_w(SEARCH_P);
  localparam logic signed [MVW-1:0] MV_MIN   = MVW'(-SEARCH_P);
  localparam logic signed [MVW-1:0] MV_MAX   = MVW'(SEARCH_P - 1);
  localparam logic [SADW-1:0]       SAD_INIT = ME_SAD_INIT[SADW-1:0];

  me_state_t             r_state;
  me_state_t             w_next;
  logic [2*LN-1:0]       r_pix;
  logic signed [MVW-1:0] r_dx;
  logic signed [MVW-1:0] r_dy;
  logic                  r_drain;
  logic                  r_vld;
  logic                  r_busy;
  logic                  r_done;
  logic [SADW-1:0]       r_best;
  logic signed [MVW-1:0] r_mvx;
  logic signed [MVW-1:0] r_mvy;
  logic [SADW-1:0]       w_acc;
  logic                  w_active;
  logic                  w_et;
  logic                  w_pix_last;
  logic                  w_cand_last;
  logic                  w_accept;
  logic                  w_issue;
  logic                  w_cand_end;
  logic                  w_update;
  logic                  w_clr;
  logic [31:0]           w_srow;
  logic [31:0]           w_scol;

  assign w_active    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_et        = ET_EN && w_active && (w_acc > r_best);
  assign w_pix_last  = &r_pix;
  assign w_cand_last = (r_dx == MV_MAX) && (r_dy == MV_MAX);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_et)            w_next = w_cand_last ? ST_DONE : ST_RUN;
        else if (w_pix_last) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_cand_end) w_next = w_cand_last ? ST_DONE : ST_RUN;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // An early-terminated candidate still has a read in flight; w_issue low drops its valid.
  always_comb begin
    w_accept   = 1'b0;
    w_issue    = 1'b0;
    w_cand_end = 1'b0;
    w_update   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_accept = start;
      end
      ST_RUN: begin
        w_issue    = !w_et;
        w_cand_end = w_et;
      end
      ST_DRAIN: begin
        w_cand_end = w_et || r_drain;
        w_update   = r_drain && !w_et && (w_acc < r_best);
      end
      default: ;
    endcase
  end

  assign w_clr = w_accept || w_cand_end;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pix   <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_drain <= 1'b0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_best  <= SAD_INIT;
      r_mvx   <= '0;
      r_mvy   <= '0;
    end else begin
      r_vld  <= w_issue;
      r_busy <= w_active;
      r_done <= (r_state == ST_DONE);
      if (w_accept) begin
        r_pix   <= '0;
        r_dx    <= MV_MIN;
        r_dy    <= MV_MIN;
        r_drain <= 1'b0;
        r_best  <= SAD_INIT;
        r_mvx   <= '0;
        r_mvy   <= '0;
      end else if (w_cand_end) begin
        r_pix   <= '0;
        r_drain <= 1'b0;
        if (r_dx == MV_MAX) begin
          r_dx <= MV_MIN;
          r_dy <= r_dy + 1'b1;
        end else begin
          r_dx <= r_dx + 1'b1;
        end
      end else if (w_issue) begin
        r_pix <= r_pix + 1'b1;
      end else if (r_state == ST_DRAIN) begin
        r_drain <= 1'b1;
      end
      // Strict compare: ties keep the earlier candidate in raster order.
      if (w_update) begin
        r_best <= w_acc;
        r_mvx  <= r_dx;
        r_mvy  <= r_dy;
      end
    end
  end

  me_sad_pe #(
    .PIX_W (PIX_W),
    .ACC_W (SADW)
  ) u_sad_pe (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clr   (w_clr),
    .i_en    (r_vld),
    .i_a     (R),
    .i_b     (S),
    .o_acc   (w_acc)
  );

  // Offset dx/dy by +P so the window coordinate is never negative.
  assign w_srow = 32'(r_pix[2*LN-1:LN]) + 32'(r_dy) + 32'(SEARCH_P);
  assign w_scol = 32'(r_pix[LN-1:0]) + 32'(r_dx) + 32'(SEARCH_P);

  assign AddressR  = (r_state == ST_RUN) ? r_pix : '0;
  assign AddressS  = (r_state == ST_RUN) ? AW_S'(w_srow * 32'(WIN) + w_scol) : '0;
  assign BestDist  = r_best;
  assign motionX   = r_mvx;
  assign motionY   = r_mvy;
  assign busy      = r_busy;
  assign completed = r_done;

endmodule

// File: tb/tb_motion_search_engine.sv
// Directed bench: two 4x4/+-2 engines (ET off / ET on) share stimulus, one 8x8/+-4 engine
// runs the larger-window scenarios; all ROMs are clocked one-cycle-latency models.
module tb_motion_search_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s, start_s, rst_m, start_m;

  logic [3:0]        ar_a, ar_b;
  logic [5:0]        as_a, as_b;
  logic [7:0]        r_a, s_a, r_b, s_b;
  logic [11:0]       bd_a, bd_b;
  logic signed [1:0] mx_a, my_a, mx_b, my_b;
  logic              busy_a, done_a, busy_b, done_b;

  logic [5:0]        ar_m;
  logic [7:0]        as_m;
  logic [7:0]        r_m, s_m;
  logic [13:0]       bd_m;
  logic signed [2:0] mx_m, my_m;
  logic              busy_m, done_m;

  logic [7:0] rom_r_s [16];
  logic [7:0] rom_s_s [49];
  logic [7:0] rom_r_m [64];
  logic [7:0] rom_s_m [225];

  int   n_checks = 0;
  int   n_pass   = 0;
  logic both_seen = 1'b0;

  motion_search_engine #(.BLOCK_N(4), .SEARCH_P(2), .PIX_W(8), .ET_EN(1'b0)) u_a (
    .clock(clk), .reset_n(rst_s), .start(start_s), .AddressR(ar_a), .R(r_a), .AddressS(as_a),
    .S(s_a), .BestDist(bd_a), .motionX(mx_a), .motionY(my_a), .busy(busy_a), .completed(done_a));

  motion_search_engine #(.BLOCK_N(4), .SEARCH_P(2), .PIX_W(8), .ET_EN(1'b1)) u_b (
    .clock(clk), .reset_n(rst_s), .start(start_s), .AddressR(ar_b), .R(r_b), .AddressS(as_b),
    .S(s_b), .BestDist(bd_b), .motionX(mx_b), .motionY(my_b), .busy(busy_b), .completed(done_b));

  motion_search_engine #(.BLOCK_N(8), .SEARCH_P(4), .PIX_W(8), .ET_EN(1'b1)) u_m (
    .clock(clk), .reset_n(rst_m), .start(start_m), .AddressR(ar_m), .R(r_m), .AddressS(as_m),
    .S(s_m), .BestDist(bd_m), .motionX(mx_m), .motionY(my_m), .busy(busy_m), .completed(done_m));

  always @(posedge clk) begin
    r_a <= rom_r_s[ar_a];
    s_a <= rom_s_s[as_a];
    r_b <= rom_r_s[ar_b];
    s_b <= rom_s_s[as_b];
    r_m <= rom_r_m[ar_m];
    s_m <= rom_s_m[as_m];
  end

  always @(negedge clk) begin
    if ((busy_a && done_a) || (busy_b && done_b) || (busy_m && done_m)) both_seen = 1'b1;
  end

  task automatic run_small(output int na, output int nb);
    start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    na = 0;
    nb = 0;
    for (int c = 1; c <= 2000 && (na == 0 || nb == 0); c++) begin
      @(posedge clk); #1;
      if (na == 0 && done_a) na = c;
      if (nb == 0 && done_b) nb = c;
    end
  endtask

  task automatic run_mid(output int n);
    start_m = 1'b1;
    @(posedge clk); #1 start_m = 1'b0;
    n = 0;
    for (int c = 1; c <= 6000; c++) begin
      @(posedge clk); #1;
      if (done_m) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_s = 1'b0; rst_m = 1'b0; start_s = 1'b0; start_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bd_a !== 12'hFFF) $display("FAIL reset_bd_a: got %h want fff", bd_a); else n_pass++;
    n_checks++; if (int'(mx_a) !== 0 || int'(my_a) !== 0) $display("FAIL reset_mv_a: got (%0d,%0d) want (0,0)", mx_a, my_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL reset_flags_a: busy %b completed %b want 0 0", busy_a, done_a); else n_pass++;
    n_checks++; if (ar_a !== 4'd0 || as_a !== 6'd0) $display("FAIL reset_addr_a: got %0d %0d want 0 0", ar_a, as_a); else n_pass++;
    n_checks++; if (bd_b !== 12'hFFF) $display("FAIL reset_bd_b: got %h want fff", bd_b); else n_pass++;
    n_checks++; if (bd_m !== 14'h3FFF) $display("FAIL reset_bd_m: got %h want 3fff", bd_m); else n_pass++;
    n_checks++; if (busy_m !== 1'b0 || done_m !== 1'b0 || as_m !== 8'd0) $display("FAIL reset_m: busy %b completed %b addrS %0d want 0 0 0", busy_m, done_m, as_m); else n_pass++;
    rst_s = 1'b1; rst_m = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_uniform();
    int n;
    for (int i = 0; i < 64; i++) rom_r_m[i] = 8'h40;
    for (int i = 0; i < 225; i++) rom_s_m[i] = 8'h40;
    run_mid(n);
    n_checks++; if (n !== 4225) $display("FAIL uniform_latency: got %0d want 4225", n); else n_pass++;
    n_checks++; if (bd_m !== 14'd0) $display("FAIL uniform_sad: got %0d want 0", bd_m); else n_pass++;
    n_checks++; if (int'(mx_m) !== -4 || int'(my_m) !== -4) $display("FAIL uniform_tie_mv: got (%0d,%0d) want (-4,-4)", mx_m, my_m); else n_pass++;
  endtask

  task automatic test_shift_match();
    int n;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) rom_r_m[i*8+j] = 8'((i*13 + j*7) & 127);
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++) rom_s_m[r*15+c] = 8'(((r*29 + c*17) & 127) | 128);
    // dy=-2 -> window row i+2, dx=3 -> window col j+7
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) rom_s_m[(i+2)*15 + (j+7)] = rom_r_m[i*8+j];
    run_mid(n);
    n_checks++; if (done_m !== 1'b1 || n == 0) $display("FAIL shift_done: completed %b after %0d cycles", done_m, n); else n_pass++;
    n_checks++; if (bd_m !== 14'd0) $display("FAIL shift_sad: got %0d want 0", bd_m); else n_pass++;
    n_checks++; if (int'(mx_m) !== 3 || int'(my_m) !== -2) $display("FAIL shift_mv: got (%0d,%0d) want (3,-2)", mx_m, my_m); else n_pass++;
  endtask

  task automatic test_et_compare();
    int na, nb;
    for (int i = 0; i < 16; i++) rom_r_s[i] = 8'd0;
    for (int i = 0; i < 49; i++) rom_s_s[i] = 8'd255;
    for (int r = 2; r < 6; r++)
      for (int c = 2; c < 6; c++) rom_s_s[r*7+c] = 8'd0;
    rom_s_s[2*7+2] = 8'd10;
    run_small(na, nb);
    n_checks++; if (na !== 289) $display("FAIL et_off_latency: got %0d want 289", na); else n_pass++;
    n_checks++; if (!(nb > 0 && nb < na)) $display("FAIL et_on_faster: got %0d cycles, ET-off run took %0d", nb, na); else n_pass++;
    n_checks++; if (bd_a !== 12'd10 || bd_b !== 12'd10) $display("FAIL et_sad: got %0d and %0d want 10", bd_a, bd_b); else n_pass++;
    n_checks++; if (int'(mx_a) !== 0 || int'(my_a) !== 0) $display("FAIL et_off_mv: got (%0d,%0d) want (0,0)", mx_a, my_a); else n_pass++;
    n_checks++; if (int'(mx_b) !== 0 || int'(my_b) !== 0) $display("FAIL et_on_mv: got (%0d,%0d) want (0,0)", mx_b, my_b); else n_pass++;
  endtask

  task automatic test_small_match();
    int na, nb;
    for (int i = 0; i < 16; i++) rom_r_s[i] = 8'(i + 1);
    for (int i = 0; i < 49; i++) rom_s_s[i] = 8'd200;
    // dy=1 -> window row i+3, dx=-2 -> window col j
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) rom_s_s[(i+3)*7 + j] = rom_r_s[i*4+j];
    rom_s_s[3*7+0] = 8'd6;
    run_small(na, nb);
    n_checks++; if (na !== 289) $display("FAIL small_latency: got %0d want 289", na); else n_pass++;
    n_checks++; if (bd_a !== 12'd5) $display("FAIL small_sad_a: got %0d want 5", bd_a); else n_pass++;
    n_checks++; if (int'(mx_a) !== -2 || int'(my_a) !== 1) $display("FAIL small_mv_a: got (%0d,%0d) want (-2,1)", mx_a, my_a); else n_pass++;
    n_checks++; if (done_b !== 1'b1 || bd_b !== 12'd5) $display("FAIL small_sad_b: completed %b sad %0d want 1 5", done_b, bd_b); else n_pass++;
    n_checks++; if (int'(mx_b) !== -2 || int'(my_b) !== 1) $display("FAIL small_mv_b: got (%0d,%0d) want (-2,1)", mx_b, my_b); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int na, nb;
    start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst_s = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bd_a !== 12'hFFF || bd_b !== 12'hFFF) $display("FAIL midreset_bd: got %h %h want fff", bd_a, bd_b); else n_pass++;
    n_checks++; if (int'(mx_a) !== 0 || int'(my_a) !== 0) $display("FAIL midreset_mv: got (%0d,%0d) want (0,0)", mx_a, my_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || busy_b !== 1'b0) $display("FAIL midreset_flags: busy %b completed %b busy_b %b want 0", busy_a, done_a, busy_b); else n_pass++;
    n_checks++; if (ar_a !== 4'd0 || as_a !== 6'd0) $display("FAIL midreset_addr: got %0d %0d want 0 0", ar_a, as_a); else n_pass++;
    rst_s = 1'b1;
    run_small(na, nb);
    n_checks++; if (na !== 289) $display("FAIL midreset_latency: got %0d want 289", na); else n_pass++;
    n_checks++; if (bd_a !== 12'd5 || int'(mx_a) !== -2 || int'(my_a) !== 1) $display("FAIL midreset_result: got %0d (%0d,%0d) want 5 (-2,1)", bd_a, mx_a, my_a); else n_pass++;
  endtask

  task automatic test_start_during_run();
    int na, nb;
    start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    na = 0;
    nb = 0;
    for (int c = 1; c <= 2000 && (na == 0 || nb == 0); c++) begin
      if (c == 20) start_s = 1'b1;
      if (c == 21) start_s = 1'b0;
      @(posedge clk); #1;
      if (na == 0 && done_a) na = c;
      if (nb == 0 && done_b) nb = c;
    end
    n_checks++; if (na !== 289) $display("FAIL ignore_start_latency: got %0d want 289", na); else n_pass++;
    n_checks++; if (bd_a !== 12'd5 || int'(mx_a) !== -2 || int'(my_a) !== 1) $display("FAIL ignore_start_result: got %0d (%0d,%0d) want 5 (-2,1)", bd_a, mx_a, my_a); else n_pass++;
    start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (done_a !== 1'b0 || busy_a !== 1'b1) $display("FAIL restart_flags_a: completed %b busy %b want 0 1", done_a, busy_a); else n_pass++;
    n_checks++; if (done_b !== 1'b0 || busy_b !== 1'b1) $display("FAIL restart_flags_b: completed %b busy %b want 0 1", done_b, busy_b); else n_pass++;
    n_checks++; if (bd_a !== 12'hFFF) $display("FAIL restart_best_init: got %h want fff", bd_a); else n_pass++;
    for (int c = 0; c < 400 && !(done_a && done_b); c++) begin
      @(posedge clk); #1;
    end
    n_checks++; if (done_a !== 1'b1 || bd_a !== 12'd5) $display("FAIL restart_result: completed %b sad %0d want 1 5", done_a, bd_a); else n_pass++;
  endtask

  task automatic test_exclusive();
    n_checks++; if (both_seen !== 1'b0) $display("FAIL busy_completed_exclusive: got overlap %b want 0", both_seen); else n_pass++;
  endtask

  initial begin
    rst_s = 1'b0;
    rst_m = 1'b0;
    start_s = 1'b0;
    start_m = 1'b0;
    for (int i = 0; i < 16; i++) rom_r_s[i] = 8'd0;
    for (int i = 0; i < 49; i++) rom_s_s[i] = 8'd0;
    for (int i = 0; i < 64; i++) rom_r_m[i] = 8'd0;
    for (int i = 0; i < 225; i++) rom_s_m[i] = 8'd0;
    test_reset();
    test_uniform();
    test_shift_match();
    test_et_compare();
    test_small_match();
    test_reset_mid_run();
    test_start_during_run();
    test_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
